// File: rtl/fht_out_reader.sv
// Purpose: unload a finished FHT frame from 4 banks and stream it in natural order.
// Latency: first sample RD_LAT+2 clocks after iSTART, then one sample per clock.
// Backpressure: iREADY low holds oDATA/oVALID; reads stop at RD_LAT+2 outstanding rows.

// Small synchronous FIFO with async active-low reset, used as the row buffer.
module fht_out_reader_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         iCLK,
    input  logic         iRESET,
    input  logic         push,
    input  logic [W-1:0] wdat,
    input  logic         pop,
    output logic         nonempty,
    output logic [W-1:0] rdat
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage: no reset needed, readers are gated by nonempty.
    always_ff @(posedge iCLK) begin
        if (push) mem[wr_ptr] <= wdat;
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign nonempty = (count != '0);
    assign rdat     = mem[rd_ptr];
endmodule

// Frame unload controller: read issue, latency tracking, row FIFO and serializer.
module fht_out_reader #(
    parameter int A_BIT  = 8,
    parameter int D_BIT  = 16,
    parameter int RD_LAT = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic             iBANK_SEL,
    output logic             oBANK_SEL,
    output logic             oRD_EN,
    output logic [A_BIT-1:0] oADDR_RD,
    input  logic [D_BIT-1:0] iDATA_0,
    input  logic [D_BIT-1:0] iDATA_1,
    input  logic [D_BIT-1:0] iDATA_2,
    input  logic [D_BIT-1:0] iDATA_3,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oLAST,
    output logic             oBUSY,
    output logic             oDONE
);
    localparam int BANK  = 1 << A_BIT;
    localparam int DEPTH = RD_LAT + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [A_BIT-1:0]        rd_addr;
    logic [A_BIT:0]          row_cnt;
    logic [1:0]              ptr;
    logic [2:0]              outst;
    logic [RD_LAT-1:0]       vld_sr;
    logic                    bank_sel;
    logic                    done;
    logic                    issue;
    logic                    start_acc;
    logic                    fifo_vld;
    logic [3:0][D_BIT-1:0]   head;
    logic                    hs;
    logic                    pop;
    logic                    last;
    logic                    last_hs;

    // Serializer handshake terms; a row leaves the FIFO with its fourth word.
    assign hs      = fifo_vld & iREADY;
    assign pop     = hs & (ptr == 2'd3);
    assign last    = fifo_vld & (ptr == 2'd3) & (row_cnt == (A_BIT + 1)'(BANK - 1));
    assign last_hs = last & iREADY;

    // Next state and read-issue decision; issue is throttled by outstanding rows.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        start_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (iSTART) begin
                    start_acc = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                issue = (outst < 3'(DEPTH));
                if (issue && (rd_addr == A_BIT'(BANK - 1))) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (last_hs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Read address, bank set latch, counters and done pulse.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd_addr  <= '0;
            bank_sel <= 1'b0;
            row_cnt  <= '0;
            ptr      <= '0;
            outst    <= '0;
            done     <= 1'b0;
        end else begin
            done <= last_hs;
            if (start_acc) begin
                rd_addr  <= '0;
                bank_sel <= iBANK_SEL;
                row_cnt  <= '0;
                ptr      <= '0;
            end else begin
                // Hold on the final address so exactly BANK reads are issued.
                if (issue && (rd_addr != A_BIT'(BANK - 1))) rd_addr <= rd_addr + 1'b1;
                if (hs)  ptr     <= ptr + 1'b1;
                if (pop) row_cnt <= row_cnt + 1'b1;
            end
            case ({issue, pop})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    // In-flight read flags, aligned so the tail marks valid bank data.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    fht_out_reader_fifo #(
        .W     (4 * D_BIT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .push     (vld_sr[RD_LAT-1]),
        .wdat     ({iDATA_3, iDATA_2, iDATA_1, iDATA_0}),
        .pop      (pop),
        .nonempty (fifo_vld),
        .rdat     (head)
    );

    assign oBANK_SEL = bank_sel;
    assign oRD_EN    = issue;
    assign oADDR_RD  = rd_addr;
    assign oVALID    = fifo_vld;
    assign oDATA     = fifo_vld ? head[ptr] : '0;
    assign oLAST     = last;
    assign oBUSY     = (state != S_IDLE);
    assign oDONE     = done;
endmodule
